// File: rtl/runner_pkg.sv
// rtl/runner_pkg.sv - shared types and helpers for the Runner game controller
//
// Purpose: game state encoding, BCD digit width and a width helper used to
// size the animation-frame and difficulty-step counters.
package runner_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int frame_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up-counter that saturates at all nines
//
// Purpose: score counter for the Runner game.
// Ports:
//   clk    - counting clock
//   reset  - synchronous, active-high clear
//   clr    - synchronous clear (new game)
//   inc    - add one this tick (ignored once every digit is 9)
//   q      - BCD value, digit 0 in the low nibble
module bcd_counter
  import runner_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [BCD_W*DIGITS-1:0]  q
);

  logic [BCD_W*DIGITS-1:0] q_inc;
  logic                    all_nines;
  logic                    carry;

  // Ripple a carry from digit 0 upward; a digit at 9 wraps to 0 and passes
  // the carry on, any other digit absorbs it.
  always_comb begin
    q_inc     = q;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q[i*BCD_W +: BCD_W] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (q[i*BCD_W +: BCD_W] == 4'd9) begin
          q_inc[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          q_inc[i*BCD_W +: BCD_W] = q[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && !all_nines) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/runner_game_ctrl.sv
// rtl/runner_game_ctrl.sv - game-flow controller for the Runner game
//
// Purpose: IDLE/RUN/PAUSE/OVER state machine, scroll difficulty divisor that
// steps down to a floor, sprite animation frame, BCD score and high score.
// Ports:
//   clk_100ms  - 100 ms game tick
//   reset      - synchronous, active-high reset (also clears hi_score)
//   start      - start/restart level; only its rising edge acts
//   pause      - pause switch level
//   collision  - runner/obstacle hit level
//   state      - 0=IDLE 1=RUN 2=PAUSE 3=OVER
//   run_en     - high while in RUN
//   diff       - scroll clock divisor
//   frame      - current animation frame
//   score      - BCD score
//   hi_score   - BCD best score
//   new_record - the last finished game beat the previous best
module runner_game_ctrl
  import runner_pkg::*;
#(
  parameter int  DIFF_W       = 8,
  parameter int  DIFF_INIT    = 60,
  parameter int  DIFF_MIN     = 20,
  parameter int  DIFF_STEP    = 4,
  parameter int  STEP_PERIOD  = 50,
  parameter int  N_FRAMES     = 2,
  parameter int  SCORE_DIGITS = 4,
  localparam int FRAME_W      = frame_width(N_FRAMES),
  localparam int SCORE_W      = BCD_W * SCORE_DIGITS
) (
  input  logic               clk_100ms,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               collision,
  output logic [1:0]         state,
  output logic               run_en,
  output logic [DIFF_W-1:0]  diff,
  output logic [FRAME_W-1:0] frame,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_record
);

  localparam int STEP_W = frame_width(STEP_PERIOD);

  game_state_e       state_q, state_d;
  logic              start_q;
  logic              start_edge;
  logic [STEP_W-1:0] step_cnt;
  logic              game_init;
  logic              advance;
  logic              record;
  logic [DIFF_W:0]   diff_sub;
  logic [DIFF_W-1:0] diff_dec;

  assign start_edge = start & ~start_q;
  assign state      = state_q;

  // State register
  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      state_q <= IDLE;
      run_en  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_en  <= (state_d == RUN);
      start_q <= start;
    end
  end

  // Next-state logic; collision outranks pause in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = RUN;
      RUN: begin
        if (collision)  state_d = OVER;
        else if (pause) state_d = PAUSE;
      end
      PAUSE:   if (!pause) state_d = RUN;
      OVER:    if (start_edge) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs for the datapath
  always_comb begin
    game_init = 1'b0;
    advance   = 1'b0;
    record    = 1'b0;
    case (state_q)
      IDLE, OVER: game_init = start_edge;
      RUN: begin
        advance = !collision && !pause;
        // Packed BCD compares correctly as an unsigned integer.
        record  = collision && (score > hi_score);
      end
      default: ;
    endcase
  end

  // One extra bit catches underflow when diff is already below DIFF_STEP.
  always_comb begin
    diff_sub = {1'b0, diff} - (DIFF_W+1)'(DIFF_STEP);
    if (diff_sub[DIFF_W] || (diff_sub < (DIFF_W+1)'(DIFF_MIN))) begin
      diff_dec = DIFF_W'(DIFF_MIN);
    end else begin
      diff_dec = diff_sub[DIFF_W-1:0];
    end
  end

  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      diff       <= DIFF_W'(DIFF_INIT);
      step_cnt   <= '0;
      frame      <= '0;
      hi_score   <= '0;
      new_record <= 1'b0;
    end else begin
      if (game_init) begin
        diff       <= DIFF_W'(DIFF_INIT);
        step_cnt   <= '0;
        frame      <= '0;
        new_record <= 1'b0;
      end else if (advance) begin
        frame <= (frame == FRAME_W'(N_FRAMES - 1)) ? '0 : frame + 1'b1;
        if (step_cnt == STEP_W'(STEP_PERIOD - 1)) begin
          step_cnt <= '0;
          diff     <= diff_dec;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
      if (record) begin
        hi_score   <= score;
        new_record <= 1'b1;
      end
    end
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk_100ms),
    .reset (reset),
    .clr   (game_init),
    .inc   (advance),
    .q     (score)
  );

endmodule

// File: tb/tb_runner_game_ctrl.sv
// tb/tb_runner_game_ctrl.sv - self-checking bench for runner_game_ctrl
module tb_runner_game_ctrl;

  logic        clk_100ms = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        pause     = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  state;
  logic        run_en;
  logic [7:0]  diff;
  logic [0:0]  frame;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        new_record;

  runner_game_ctrl dut (
    .clk_100ms  (clk_100ms),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .collision  (collision),
    .state      (state),
    .run_en     (run_en),
    .diff       (diff),
    .frame      (frame),
    .score      (score),
    .hi_score   (hi_score),
    .new_record (new_record)
  );

  always #5 clk_100ms = ~clk_100ms;

  typedef struct {
    logic [1:0]  st;
    logic        run;
    logic [7:0]  diff;
    logic        fr;
    logic [15:0] sc;
    logic [15:0] hi;
    logic        nr;
  } exp_t;

  typedef struct {
    bit   s;
    bit   p;
    bit   c;
    exp_t e;
  } vec_t;

  int   total  = 0;
  int   bad    = 0;
  int   tick_n = 0;
  exp_t sb[$];

  // Reference model, decimal arithmetic
  int m_state, m_score, m_hi, m_diff, m_frame, m_step;
  bit m_nr, m_start_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_init();
    m_score = 0; m_diff = 60; m_step = 0; m_frame = 0; m_nr = 1'b0; m_state = 1;
  endtask

  task automatic model_step(input bit rst, input bit s, input bit p, input bit c);
    bit se;
    se = s && !m_start_q;
    if (rst) begin
      m_state = 0; m_score = 0; m_hi = 0; m_diff = 60; m_frame = 0;
      m_step = 0; m_nr = 1'b0; m_start_q = 1'b0;
    end else begin
      m_start_q = s;
      case (m_state)
        0: if (se) model_init();
        1: begin
          if (c) begin
            if (m_score > m_hi) begin
              m_hi = m_score;
              m_nr = 1'b1;
            end
            m_state = 3;
          end else if (p) begin
            m_state = 2;
          end else begin
            m_score = (m_score >= 9999) ? 9999 : m_score + 1;
            m_frame = (m_frame + 1) % 2;
            m_step  = m_step + 1;
            if (m_step == 50) begin
              m_step = 0;
              m_diff = (m_diff - 4 < 20) ? 20 : m_diff - 4;
            end
          end
        end
        2: if (!p) m_state = 1;
        default: if (se) model_init();
      endcase
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.st   = 2'(m_state);
    e.run  = (m_state == 1);
    e.diff = 8'(m_diff);
    e.fr   = m_frame[0];
    e.sc   = to_bcd(m_score);
    e.hi   = to_bcd(m_hi);
    e.nr   = m_nr;
    return e;
  endfunction

  task automatic tick_x(input bit rst, input bit s, input bit p, input bit c,
                        input bit use_tbl, input exp_t te);
    exp_t e;
    reset = rst; start = s; pause = p; collision = c;
    model_step(rst, s, p, c);
    if (use_tbl) sb.push_back(te);
    else         sb.push_back(model_exp());
    @(posedge clk_100ms);
    #1;
    tick_n++;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL t%0d scoreboard: got=empty want=entry", tick_n);
    end else begin
      e = sb.pop_front();
      chk($sformatf("t%0d state", tick_n), 32'(state), 32'(e.st));
      chk($sformatf("t%0d run_en", tick_n), 32'(run_en), 32'(e.run));
      chk($sformatf("t%0d diff", tick_n), 32'(diff), 32'(e.diff));
      chk($sformatf("t%0d frame", tick_n), 32'(frame), 32'(e.fr));
      chk($sformatf("t%0d score", tick_n), 32'(score), 32'(e.sc));
      chk($sformatf("t%0d hi_score", tick_n), 32'(hi_score), 32'(e.hi));
      chk($sformatf("t%0d new_record", tick_n), 32'(new_record), 32'(e.nr));
    end
  endtask

  task automatic tick(input bit rst, input bit s, input bit p, input bit c);
    exp_t z;
    z = '{st: 2'd0, run: 1'b0, diff: 8'd0, fr: 1'b0, sc: 16'h0, hi: 16'h0, nr: 1'b0};
    tick_x(rst, s, p, c, 1'b0, z);
  endtask

  task automatic run(input int n, input bit s, input bit p, input bit c);
    for (int i = 0; i < n; i++) tick(1'b0, s, p, c);
  endtask

  function automatic vec_t mk(bit s, bit p, bit c, logic [1:0] st, bit run_v, int dv,
                              bit fr, logic [15:0] sc, logic [15:0] hi, bit nr);
    vec_t v;
    v.s = s; v.p = p; v.c = c;
    v.e.st = st; v.e.run = run_v; v.e.diff = 8'(dv); v.e.fr = fr;
    v.e.sc = sc; v.e.hi = hi; v.e.nr = nr;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    //          s p c  st run diff fr score    hi       nr
    vt[0]  = mk(0,0,0, 0, 0, 60, 0, 16'h0000, 16'h0000, 0);
    vt[1]  = mk(0,0,1, 0, 0, 60, 0, 16'h0000, 16'h0000, 0);
    vt[2]  = mk(0,1,0, 0, 0, 60, 0, 16'h0000, 16'h0000, 0);
    vt[3]  = mk(1,0,0, 1, 1, 60, 0, 16'h0000, 16'h0000, 0);
    vt[4]  = mk(1,0,0, 1, 1, 60, 1, 16'h0001, 16'h0000, 0);
    vt[5]  = mk(0,0,0, 1, 1, 60, 0, 16'h0002, 16'h0000, 0);
    vt[6]  = mk(0,1,0, 2, 0, 60, 0, 16'h0002, 16'h0000, 0);
    vt[7]  = mk(0,1,1, 2, 0, 60, 0, 16'h0002, 16'h0000, 0);
    vt[8]  = mk(1,1,0, 2, 0, 60, 0, 16'h0002, 16'h0000, 0);
    vt[9]  = mk(0,0,0, 1, 1, 60, 0, 16'h0002, 16'h0000, 0);
    vt[10] = mk(0,0,0, 1, 1, 60, 1, 16'h0003, 16'h0000, 0);
    vt[11] = mk(0,1,1, 3, 0, 60, 1, 16'h0003, 16'h0003, 1);
    vt[12] = mk(0,0,0, 3, 0, 60, 1, 16'h0003, 16'h0003, 1);
    vt[13] = mk(1,0,1, 1, 1, 60, 0, 16'h0000, 16'h0003, 0);
    vt[14] = mk(0,0,1, 3, 0, 60, 0, 16'h0000, 16'h0003, 0);

    tick(1'b1, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick_x(1'b0, vt[i].s, vt[i].p, vt[i].c, 1'b1, vt[i].e);

    // Difficulty ramp and floor, score and frame over a long run
    tick(1'b1, 0, 0, 0);
    run(2, 0, 0, 0);
    tick(1'b0, 1, 0, 0);
    chk("p1 state@start", 32'(state), 32'd1);
    chk("p1 diff@start", 32'(diff), 32'd60);
    run(50, 0, 0, 0);
    chk("p1 diff@50", 32'(diff), 32'd56);
    run(73, 0, 0, 0);
    chk("p2 score@123", 32'(score), 32'h0123);
    chk("p2 run_en@123", 32'(run_en), 32'd1);
    run(377, 0, 0, 0);
    chk("p1 diff@500", 32'(diff), 32'd20);
    run(100, 0, 0, 0);
    chk("p1 diff@600", 32'(diff), 32'd20);

    // Pause freezes counters; release resumes one tick later
    tick(1'b0, 0, 0, 1);
    tick(1'b0, 1, 0, 0);
    run(20, 0, 0, 0);
    chk("p3 score@20", 32'(score), 32'h0020);
    run(10, 0, 1, 0);
    chk("p3 paused state", 32'(state), 32'd2);
    chk("p3 paused score", 32'(score), 32'h0020);
    tick(1'b0, 0, 0, 0);
    chk("p3 release state", 32'(state), 32'd1);
    chk("p3 release score", 32'(score), 32'h0020);
    tick(1'b0, 0, 0, 0);
    chk("p3 resume score", 32'(score), 32'h0021);

    // High score kept across games, only beaten scores set new_record
    tick(1'b1, 0, 0, 0);
    tick(1'b0, 1, 0, 0);
    run(42, 0, 0, 0);
    tick(1'b0, 0, 0, 1);
    chk("p4 over state", 32'(state), 32'd3);
    chk("p4 hi 42", 32'(hi_score), 32'h0042);
    chk("p4 record", 32'(new_record), 32'd1);
    tick(1'b0, 1, 0, 0);
    chk("p4 restart score", 32'(score), 32'd0);
    chk("p4 restart record", 32'(new_record), 32'd0);
    run(30, 0, 0, 0);
    tick(1'b0, 0, 0, 1);
    chk("p4 hi kept", 32'(hi_score), 32'h0042);
    chk("p4 no record", 32'(new_record), 32'd0);

    // Start held through the collision must not restart
    tick(1'b0, 0, 0, 0);
    tick(1'b0, 1, 0, 0);
    run(5, 1, 0, 0);
    tick(1'b0, 1, 0, 1);
    run(3, 1, 0, 0);
    chk("p5 held start", 32'(state), 32'd3);
    tick(1'b0, 0, 0, 0);
    tick(1'b0, 1, 0, 0);
    chk("p5 re-edge", 32'(state), 32'd1);

    // Saturation, then reset mid-RUN
    run(10000, 0, 0, 0);
    chk("p6 saturate", 32'(score), 32'h9999);
    tick(1'b1, 0, 0, 0);
    chk("p6 rst state", 32'(state), 32'd0);
    chk("p6 rst run_en", 32'(run_en), 32'd0);
    chk("p6 rst diff", 32'(diff), 32'd60);
    chk("p6 rst frame", 32'(frame), 32'd0);
    chk("p6 rst score", 32'(score), 32'd0);
    chk("p6 rst hi", 32'(hi_score), 32'd0);
    chk("p6 rst record", 32'(new_record), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
